// File: rtl/noc_peek_pkg.sv
// Shared types and constants for the UART-to-NoC peek bridge.
package noc_peek_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, ID, WAIT, SEND} peek_state_t;

    localparam logic [7:0] PEEK_OPCODE = 8'hA5;
    localparam int         PEEK_BYTES  = 4;
endpackage

// File: rtl/uart_peek_bridge_if.sv
// UART byte handshake plus NoC peek port, bundled for the bridge and its host-side driver.
interface uart_peek_bridge_if #(
    parameter int ID_W = 4
);
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [31:0]     peek_addr;
    logic [ID_W-1:0] peek_id;
    logic [31:0]     peek_data;

    modport master (
        output rx_data, rx_valid, tx_ready, peek_data,
        input  tx_data, tx_valid, peek_addr, peek_id
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready, peek_data,
        output tx_data, tx_valid, peek_addr, peek_id
    );
endinterface

// File: rtl/uart_peek_bridge_byte_serializer.sv
// Streams a loaded 32-bit word out LSB-first as bytes over a valid/ready handshake.
module byte_serializer
    import noc_peek_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        done
);
    logic [31:0]           shiftWord;
    logic [PEEK_BYTES-1:0] pending;
    logic                  xfer;

    // One bit per byte still owed; the low byte of shiftWord is always the one on the wire.
    assign txValid = pending[0];
    assign txData  = shiftWord[7:0];
    assign xfer    = txValid & txReady;
    assign done    = xfer & (pending == PEEK_BYTES'(1));

    // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftWord <= '0;
            pending   <= '0;
        end else if (load) begin
            shiftWord <= word;
            pending   <= '1;
        end else if (xfer) begin
            shiftWord <= {8'h00, shiftWord[31:8]};
            pending   <= pending >> 1;
        end
    end
endmodule

// File: rtl/uart_peek_bridge.sv
// Parses A5-framed peek requests from UART RX, peeks the NoC, returns the word as 4 TX bytes.
module uart_peek_bridge
    import noc_peek_pkg::*;
#(
    parameter int ID_W        = 4,
    parameter int PEEK_LAT    = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst,
    uart_peek_bridge_if.slave  bus,
    output logic               busy,
    output logic [7:0]         drop_cnt
);
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    localparam int LAT_W = $clog2(PEEK_LAT + 2);

    peek_state_t      state, stateNext;
    logic [1:0]       addrIdx;
    logic [GAP_W-1:0] gapCnt;
    logic [LAT_W-1:0] waitCnt;
    logic             gapActive, timeout, dropByte, loadWord, txDone;

    assign gapActive = (state == ADDR) || (state == ID);
    assign timeout   = gapActive && (gapCnt == GAP_W'(TIMEOUT_CYC));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // NOTE: every output gets a default first, so no path through this block infers a latch.
    always_comb begin
        stateNext = state;
        dropByte  = 1'b0;
        loadWord  = 1'b0;
        unique case (state)
            IDLE: if (bus.rx_valid) begin
                if (bus.rx_data == PEEK_OPCODE) stateNext = ADDR;
                else                            dropByte  = 1'b1;
            end
            // A timeout outranks a byte arriving on the same cycle; that byte is the one dropped.
            ADDR: if (timeout) begin
                stateNext = IDLE;
                dropByte  = 1'b1;
            end else if (bus.rx_valid && addrIdx == 2'(PEEK_BYTES - 1)) begin
                stateNext = ID;
            end
            ID: if (timeout) begin
                stateNext = IDLE;
                dropByte  = 1'b1;
            end else if (bus.rx_valid) begin
                stateNext = WAIT;
            end
            WAIT: begin
                dropByte = bus.rx_valid;
                if (waitCnt == LAT_W'(PEEK_LAT)) begin
                    loadWord  = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                dropByte = bus.rx_valid;
                if (txDone) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addrIdx       <= '0;
            gapCnt        <= '0;
            waitCnt       <= '0;
            drop_cnt      <= '0;
            bus.peek_addr <= '0;
            bus.peek_id   <= '0;
        end else begin
            if (dropByte && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            gapCnt  <= (gapActive && !bus.rx_valid && !timeout) ? gapCnt + 1'b1 : '0;
            waitCnt <= (state == WAIT) ? waitCnt + 1'b1 : '0;
            // Address/id registers are only written by frame bytes, so they hold across abort.
            if (state == ADDR && bus.rx_valid && !timeout) begin
                bus.peek_addr[8*addrIdx +: 8] <= bus.rx_data;
                addrIdx                       <= addrIdx + 2'd1;
            end else if (state != ADDR) begin
                addrIdx <= '0;
            end
            if (state == ID && bus.rx_valid && !timeout) bus.peek_id <= bus.rx_data[ID_W-1:0];
        end
    end

    byte_serializer u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (loadWord),
        .word    (bus.peek_data),
        .txData  (bus.tx_data),
        .txValid (bus.tx_valid),
        .txReady (bus.tx_ready),
        .done    (txDone)
    );
endmodule

// File: tb/tb_uart_peek_bridge.sv
// Directed bench for uart_peek_bridge: framing, stalls, drops, timeout, reset, saturation.
module tb_uart_peek_bridge;
    import noc_peek_pkg::*;

    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic [7:0] drop_cnt;
    int checks = 0;
    int errors = 0;
    logic [7:0] txQ[$];
    bit stallChk = 1'b0;
    bit prevStall = 1'b0;
    logic [7:0] prevData = '0;

    uart_peek_bridge_if #(.ID_W(4)) bus ();

    uart_peek_bridge #(.ID_W(4), .PEEK_LAT(2), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Collects TX transfers and checks that a stalled byte holds still.
    always @(negedge clk) begin
        if (stallChk && prevStall) begin
            check("stall_valid", 32'(bus.tx_valid), 32'd1);
            check("stall_data", 32'(bus.tx_data), 32'(prevData));
        end
        prevStall = bus.tx_valid & !bus.tx_ready;
        prevData  = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) txQ.push_back(bus.tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [31:0] addr, input logic [7:0] id);
        sendByte(PEEK_OPCODE);
        for (int i = 0; i < 4; i++) sendByte(addr[8*i +: 8]);
        sendByte(id);
    endtask

    task automatic waitIdle(input int budget, input bit toggle);
        int n = 0;
        while (busy && n < budget) begin
            bus.tx_ready = toggle ? (n % 3 == 0) : 1'b1;
            tick();
            n++;
        end
        bus.tx_ready = 1'b1;
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic waitTxValid(input int budget);
        int n = 0;
        while (!bus.tx_valid && n < budget) begin
            tick();
            n++;
        end
        check("tx_valid_seen", 32'(bus.tx_valid), 32'd1);
    endtask

    task automatic checkResp(input string tag, input logic [31:0] word);
        check({tag, "_len"}, 32'(txQ.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (txQ.size() > i) check($sformatf("%s_b%0d", tag, i), 32'(txQ[i]), 32'(word[8*i +: 8]));
        txQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.peek_data = '0;
        repeat (3) tick();
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_addr", bus.peek_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // 1: basic frame, checked latency from last frame byte to first tx_valid
        bus.peek_data = 32'hDEADBEEF;
        sendFrame(32'h0000_0010, 8'h03);
        check("t1_addr", bus.peek_addr, 32'h10);
        check("t1_id", 32'(bus.peek_id), 32'd3);
        repeat (2) tick();
        check("t1_lat_early", 32'(bus.tx_valid), 32'd0);
        tick();
        check("t1_lat", 32'(bus.tx_valid), 32'd1);
        waitIdle(50, 1'b0);
        check("t1_tx_valid_off", 32'(bus.tx_valid), 32'd0);
        checkResp("t1", 32'hDEADBEEF);

        // 2: same frame with tx_ready high one cycle in three
        stallChk = 1'b1;
        sendFrame(32'h0000_0010, 8'h03);
        waitIdle(100, 1'b1);
        checkResp("t2", 32'hDEADBEEF);
        check("t2_drop", 32'(drop_cnt), 32'd0);

        // 3: stray bytes, then a frame whose id byte has upper bits set
        sendByte(8'h00);
        sendByte(8'hFF);
        check("t3_drop", 32'(drop_cnt), 32'd2);
        bus.peek_data = 32'h11223344;
        sendFrame(32'h0403_0201, 8'hF3);
        check("t3_addr", bus.peek_addr, 32'h0403_0201);
        check("t3_id", 32'(bus.peek_id), 32'd3);
        waitIdle(50, 1'b0);
        checkResp("t3", 32'h11223344);

        // 4: abandoned frame times out exactly TMO+1 cycles after its last byte
        sendByte(PEEK_OPCODE);
        sendByte(8'h10);
        repeat (TMO) tick();
        check("t4_busy_before", 32'(busy), 32'd1);
        tick();
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_drop", 32'(drop_cnt), 32'd3);
        check("t4_addr_partial", bus.peek_addr, 32'h0403_0210);
        check("t4_no_tx", 32'(txQ.size()), 32'd0);
        bus.peek_data = 32'hCAFEF00D;
        sendFrame(32'h0000_0020, 8'h05);
        waitIdle(50, 1'b0);
        checkResp("t4", 32'hCAFEF00D);

        // 5: bytes during WAIT and a stalled SEND are dropped; the held word is unaffected
        bus.peek_data = 32'h0BADC0DE;
        sendFrame(32'h0000_0030, 8'h01);
        sendByte(8'h55);
        waitTxValid(20);
        bus.tx_ready  = 1'b0;
        bus.peek_data = 32'hFFFFFFFF;
        sendByte(PEEK_OPCODE);
        sendByte(8'h11);
        sendByte(8'h22);
        check("t5_busy_stalled", 32'(busy), 32'd1);
        waitIdle(50, 1'b0);
        checkResp("t5", 32'h0BADC0DE);
        check("t5_drop", 32'(drop_cnt), 32'd7);
        repeat (3) tick();
        check("t5_no_new_frame", 32'(busy), 32'd0);
        stallChk = 1'b0;

        // 6: reset after the second response byte, then drop counter saturation
        bus.peek_data = 32'h01020304;
        sendFrame(32'h0000_0040, 8'h02);
        for (int n = 0; n < 20 && txQ.size() < 2; n++) tick();
        check("t6_two_bytes", 32'(txQ.size()), 32'd2);
        rst          = 1'b1;
        bus.tx_ready = 1'b0;
        tick();
        check("t6_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("t6_tx_data", 32'(bus.tx_data), 32'd0);
        check("t6_addr", bus.peek_addr, 32'd0);
        check("t6_id", 32'(bus.peek_id), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_drop_rst", 32'(drop_cnt), 32'd0);
        rst          = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (5) tick();
        check("t6_no_more_tx", 32'(txQ.size()), 32'd2);
        if (txQ.size() == 2) begin
            check("t6_b0", 32'(txQ[0]), 32'h04);
            check("t6_b1", 32'(txQ[1]), 32'h03);
        end
        txQ.delete();
        for (int i = 0; i < 254; i++) sendByte(8'(i) & 8'h7F);
        check("t6_drop_254", 32'(drop_cnt), 32'hFE);
        for (int i = 0; i < 46; i++) sendByte(8'(i) & 8'h7F);
        check("t6_drop_sat", 32'(drop_cnt), 32'hFF);
        check("t6_busy_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
